// File: rtl/control_subcmd_arbiter.sv
// control_subcmd_arbiter: round-robin owner of the single frame-RAM write port.
// Ports: clk, reset (async, active-low); req/grant/eng_done/eng_ack per engine;
// eng_row/eng_column/eng_pixel/eng_data/eng_we packed engine write buses;
// row/column/pixel/data_out/ram_write_enable to RAM; busy, owner, timeout_err.
// Optional grant watchdog: define CONTROL_SUBCMD_ARBITER_TIMEOUT_EN.
package params_pkg;
  localparam int BYTES_PER_PIXEL = 3;
endpackage

module control_subcmd_arbiter
  import params_pkg::*;
#(
  parameter int PIXEL_WIDTH    = 64,
  parameter int PIXEL_HEIGHT   = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES =
    PIXEL_WIDTH * PIXEL_HEIGHT * BYTES_PER_PIXEL + 8,
  localparam int CB = $clog2(PIXEL_WIDTH),
  localparam int RB = $clog2(PIXEL_HEIGHT),
  localparam int OB = $clog2(NUM_REQ),
  localparam int PB = $clog2(BYTES_PER_PIXEL)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    grant,
  input  logic [NUM_REQ*RB-1:0] eng_row,
  input  logic [NUM_REQ*CB-1:0] eng_column,
  input  logic [NUM_REQ*PB-1:0] eng_pixel,
  input  logic [NUM_REQ*8-1:0]  eng_data,
  input  logic [NUM_REQ-1:0]    eng_we,
  input  logic [NUM_REQ-1:0]    eng_done,
  output logic [NUM_REQ-1:0]    eng_ack,
  output logic [RB-1:0]         row,
  output logic [CB-1:0]         column,
  output logic [PB-1:0]         pixel,
  output logic [7:0]            data_out,
  output logic                  ram_write_enable,
  output logic                  busy,
  output logic [OB-1:0]         owner,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACK,
    RELEASE
  } state_t;

  state_t        state, state_n;
  logic [OB-1:0] owner_n;
  logic [OB-1:0] rr, rr_n;
  logic [OB-1:0] pick;
  logic          found;
  logic [NUM_REQ-1:0] owner_oh;
  logic          to_hit;

  // first requester at or above rr, wrapping
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = OB'(idx);
      end
    end
  end

`ifdef CONTROL_SUBCMD_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt;

  // cnt = (GRANT cycle number - 1); zero whenever not in GRANT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state != GRANT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign to_hit = (cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= '0;
      rr    <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr    <= rr_n;
    end
  end

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    rr_n        = rr;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_n = pick;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // done beats a same-cycle abort or expiry
        if (eng_done[owner]) begin
          state_n = ACK;
        end else if (!req[owner]) begin
          state_n = RELEASE;
        end else if (to_hit) begin
          timeout_err = 1'b1;
          state_n     = RELEASE;
        end
      end
      ACK: begin
        state_n = RELEASE;
      end
      RELEASE: begin
        rr_n    = (owner == OB'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign owner_oh = NUM_REQ'(1) << owner;

  assign grant = (state == GRANT || state == ACK) ? owner_oh : '0;
  assign eng_ack = (state == ACK) ? owner_oh : '0;
  assign busy = (state != IDLE);
  assign ram_write_enable = (state == GRANT) && eng_we[owner];

  always_comb begin
    row      = '0;
    column   = '0;
    pixel    = '0;
    data_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OB'(i)) begin
        row      = eng_row[i*RB +: RB];
        column   = eng_column[i*CB +: CB];
        pixel    = eng_pixel[i*PB +: PB];
        data_out = eng_data[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_control_subcmd_arbiter.sv
// tb_control_subcmd_arbiter: directed bench for control_subcmd_arbiter.
// Default geometry 64x32, 4 requesters, 3 bytes per pixel.
module tb_control_subcmd_arbiter;

  localparam int N  = 4;
  localparam int RB = 5;
  localparam int CB = 6;
  localparam int PB = 2;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [N*RB-1:0] eng_row;
  logic [N*CB-1:0] eng_column;
  logic [N*PB-1:0] eng_pixel;
  logic [N*8-1:0]  eng_data;
  logic [N-1:0]    eng_we;
  logic [N-1:0]    eng_done;
  logic [N-1:0]    eng_ack;
  logic [RB-1:0]   row;
  logic [CB-1:0]   column;
  logic [PB-1:0]   pixel;
  logic [7:0]      data_out;
  logic            ram_write_enable;
  logic            busy;
  logic [1:0]      owner;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;

  control_subcmd_arbiter #(
    .PIXEL_WIDTH(64),
    .PIXEL_HEIGHT(32),
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .grant(grant),
    .eng_row(eng_row),
    .eng_column(eng_column),
    .eng_pixel(eng_pixel),
    .eng_data(eng_data),
    .eng_we(eng_we),
    .eng_done(eng_done),
    .eng_ack(eng_ack),
    .row(row),
    .column(column),
    .pixel(pixel),
    .data_out(data_out),
    .ram_write_enable(ram_write_enable),
    .busy(busy),
    .owner(owner),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (grant != '0) begin
        ok = 1'b1;
        break;
      end
      step;
    end
  endtask

  bit ok;
  logic [31:0] exp_bus;

  initial begin
    reset      = 1'b0;
    req        = '0;
    eng_row    = '0;
    eng_column = '0;
    eng_pixel  = '0;
    eng_data   = '0;
    eng_we     = '0;
    eng_done   = '0;
    step;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_ack", eng_ack, 0);
    chk("rst_rwe", ram_write_enable, 0);
    chk("rst_to", timeout_err, 0);
    reset = 1'b1;
    step;

    // single requester, 4x4 area of 3-byte pixels
    eng_row[RB +: RB]    = '1;
    eng_column[CB +: CB] = '1;
    eng_pixel[PB +: PB]  = '1;
    eng_data[8 +: 8]     = '1;
    eng_we[1]            = 1'b1;
    req = 4'b0001;
    #1;
    chk("t1_grant_pre", grant, 0);
    step;
    chk("t1_grant", grant, 4'b0001);
    chk("t1_busy", busy, 1);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        for (int p = 0; p < 3; p++) begin
          eng_row[0 +: RB]    = RB'(5 + r);
          eng_column[0 +: CB] = CB'(10 + c);
          eng_pixel[0 +: PB]  = PB'(p);
          eng_data[0 +: 8]    = 8'(r * 16 + c * 4 + p);
          eng_we[0]           = 1'b1;
          #1;
          exp_bus = {11'b0, 5'(5 + r), 6'(10 + c), 2'(p),
                     8'(r * 16 + c * 4 + p)};
          chk("t1_rwe", ram_write_enable, 1);
          chk("t1_bus", {11'b0, row, column, pixel, data_out}, exp_bus);
          step;
        end
      end
    end
    eng_we   = '0;
    eng_done = 4'b0001;
    #1;
    chk("t1_rwe_off", ram_write_enable, 0);
    chk("t1_ack_pre", eng_ack, 0);
    step;
    eng_we = 4'b0001;
    #1;
    chk("t1_ack", eng_ack, 4'b0001);
    chk("t1_grant_ack", grant, 4'b0001);
    chk("t1_rwe_ack", ram_write_enable, 0);
    eng_we   = '0;
    eng_done = '0;
    req      = '0;
    step;
    chk("t1_grant_rel", grant, 0);
    chk("t1_ack_rel", eng_ack, 0);
    chk("t1_busy_rel", busy, 1);
    step;
    chk("t1_idle", busy, 0);

    // round robin from rr=0
    reset = 1'b0;
    step;
    reset = 1'b1;
    req   = 4'b1111;
    for (int e = 0; e < 5; e++) begin
      wait_grant(ok);
      chk("rr_wait", {31'b0, ok}, 1);
      chk("rr_grant", grant, 1 << (e % 4));
      chk("rr_owner", owner, e % 4);
      chk("rr_onehot", {31'b0, $onehot0(grant)}, 1);
      eng_done = grant;
      step;
      chk("rr_ack", eng_ack, 1 << (e % 4));
      chk("rr_onehot_ack", {31'b0, $onehot0(grant)}, 1);
      eng_done = '0;
      step;
    end
    req = '0;
    step;
    chk("rr_idle", busy, 0);

    // non-owner write/done ignored; rr now 1
    req = 4'b0010;
    step;
    chk("t3_grant", grant, 4'b0010);
    eng_data[8 +: 8]  = 8'h3c;
    eng_data[16 +: 8] = 8'ha5;
    eng_we   = 4'b0100;
    eng_done = 4'b0100;
    #1;
    chk("t3_rwe_other", ram_write_enable, 0);
    eng_we = 4'b0110;
    #1;
    chk("t3_rwe_own", ram_write_enable, 1);
    chk("t3_data", data_out, 8'h3c);
    step;
    chk("t3_still_grant", grant, 4'b0010);
    chk("t3_no_ack", eng_ack, 0);
    eng_we   = '0;
    eng_done = '0;

    // abort by dropping req[1]
    req = '0;
    step;
    chk("t4_grant", grant, 0);
    chk("t4_ack", eng_ack, 0);
    chk("t4_busy", busy, 1);
    step;
    chk("t4_idle", busy, 0);
    req = 4'b1111;
    wait_grant(ok);
    chk("t4_wait", {31'b0, ok}, 1);
    chk("t4_rr2", grant, 4'b0100);
    chk("t4_owner", owner, 2);

    // async reset mid-GRANT
    eng_we = 4'b0100;
    #1;
    chk("t5_rwe_pre", ram_write_enable, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rwe", ram_write_enable, 0);
    chk("t5_grant", grant, 0);
    chk("t5_busy", busy, 0);
    chk("t5_owner", owner, 0);
    eng_we = '0;
    req    = 4'b1010;
    @(negedge clk);
    reset = 1'b1;
    #1;
    wait_grant(ok);
    chk("t5_wait", {31'b0, ok}, 1);
    chk("t5_lowest", grant, 4'b0010);

    // done and abort together: done wins
    req      = '0;
    eng_done = 4'b0010;
    step;
    chk("t5_done_wins", eng_ack, 4'b0010);
    chk("t5_grant_ack", grant, 4'b0010);
    eng_done = '0;
    step;
    chk("t5_rel", grant, 0);
    step;

    // watchdog
    req = 4'b0001;
    wait_grant(ok);
    chk("t6_wait", {31'b0, ok}, 1);
`ifdef CONTROL_SUBCMD_ARBITER_TIMEOUT_EN
    for (int n = 2; n <= 15; n++) step;
    chk("t6_to15", timeout_err, 0);
    step;
    chk("t6_to16", timeout_err, 1);
    chk("t6_grant16", grant, 4'b0001);
    step;
    chk("t6_grant17", grant, 0);
    chk("t6_to17", timeout_err, 0);
`else
    for (int n = 2; n <= 100; n++) step;
    chk("t6_grant100", grant, 4'b0001);
    chk("t6_to100", timeout_err, 0);
`endif
    req = '0;
    step;
    step;
    chk("end_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
